// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: single-outstanding AXI4 slave backed by a 64-bit word memory.
// Bursts are treated as INCR with 8-byte beats. Beats outside the mapped window
// are suppressed on write and return zero on read, both flagged with SLVERR.
module axi4_mem_responder #(
  parameter int                ID_W   = 4,
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              axi_aw_valid,
  output logic              axi_aw_ready,
  input  logic [ID_W-1:0]   axi_aw_id,
  input  logic [ADDR_W-1:0] axi_aw_addr,
  input  logic [7:0]        axi_aw_len,
  input  logic              axi_w_valid,
  output logic              axi_w_ready,
  input  logic [63:0]       axi_w_data,
  input  logic [7:0]        axi_w_strb,
  input  logic              axi_w_last,
  output logic              axi_b_valid,
  input  logic              axi_b_ready,
  output logic [ID_W-1:0]   axi_b_id,
  output logic [1:0]        axi_b_resp,
  input  logic              axi_ar_valid,
  output logic              axi_ar_ready,
  input  logic [ID_W-1:0]   axi_ar_id,
  input  logic [ADDR_W-1:0] axi_ar_addr,
  input  logic [7:0]        axi_ar_len,
  output logic              axi_r_valid,
  input  logic              axi_r_ready,
  output logic [ID_W-1:0]   axi_r_id,
  output logic [63:0]       axi_r_data,
  output logic [1:0]        axi_r_resp,
  output logic              axi_r_last
);

  // Word index is the byte offset from BASE in 8-byte units; it wraps naturally.
  localparam int IW = ADDR_W - 3;
  localparam int MW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ID_W-1:0]   id_r;
  logic [IW-1:0]     idx_r;
  logic [7:0]        len_r;
  logic [7:0]        cnt_r;
  logic              err_r;
  logic              r_valid_r;
  logic              r_last_r;
  logic [1:0]        r_resp_r;
  logic [63:0]       rd_word_r;
  logic [63:0]       mem_r [DEPTH];

  logic              aw_hs_s;
  logic              ar_hs_s;
  logic              w_hs_s;
  logic              b_hs_s;
  logic              r_hs_s;
  logic              beat_last_s;
  logic [IW-1:0]     idx_inc_s;
  logic [IW-1:0]     rd_idx_s;
  logic              unused_s;

  // Byte address to word index relative to BASE; addresses below BASE wrap to huge indices.
  function automatic logic [IW-1:0] word_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return IW'(off >> 3'd3);
  endfunction

  // A word index is mapped when no bit at or above log2(DEPTH) is set.
  function automatic logic in_range(input logic [IW-1:0] idx);
    return (idx >> MW) == {IW{1'b0}};
  endfunction

  assign aw_hs_s     = (state_r == IDLE) && axi_aw_valid;
  assign ar_hs_s     = (state_r == IDLE) && axi_ar_valid && !axi_aw_valid;
  assign w_hs_s      = (state_r == WDATA) && axi_w_valid;
  assign b_hs_s      = (state_r == WRESP) && axi_b_ready;
  assign r_hs_s      = (state_r == RDATA) && r_valid_r && axi_r_ready;
  assign beat_last_s = (cnt_r == len_r);
  assign idx_inc_s   = idx_r + IW'(1'b1);
  assign rd_idx_s    = ar_hs_s ? word_index(axi_ar_addr) : idx_inc_s;
  // Burst end is decided by the beat counter, so w_last carries no information here.
  assign unused_s    = axi_w_last;

  assign axi_aw_ready = (state_r == IDLE);
  assign axi_ar_ready = (state_r == IDLE) && !axi_aw_valid;
  assign axi_w_ready  = (state_r == WDATA);
  assign axi_b_valid  = (state_r == WRESP);
  assign axi_b_id     = id_r;
  assign axi_b_resp   = err_r ? 2'b10 : 2'b00;
  assign axi_r_valid  = r_valid_r;
  assign axi_r_id     = id_r;
  assign axi_r_resp   = r_resp_r;
  assign axi_r_last   = r_last_r;
  assign axi_r_data   = (r_resp_r == 2'b10) ? 64'h0 : rd_word_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: one transaction at a time, writes win ties in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
          state_nxt_s = WDATA;
        end else if (ar_hs_s) begin
          state_nxt_s = RDATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WDATA: begin
        if (w_hs_s && beat_last_s) begin
          state_nxt_s = WRESP;
        end else begin
          state_nxt_s = WDATA;
        end
      end
      WRESP: begin
        if (b_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRESP;
        end
      end
      RDATA: begin
        if (r_hs_s && r_last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RDATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction context, beat counting, error accumulation and read-beat attributes.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_r      <= {ID_W{1'b0}};
      idx_r     <= {IW{1'b0}};
      len_r     <= 8'd0;
      cnt_r     <= 8'd0;
      err_r     <= 1'b0;
      r_valid_r <= 1'b0;
      r_last_r  <= 1'b0;
      r_resp_r  <= 2'b00;
    end else if (aw_hs_s) begin
      id_r  <= axi_aw_id;
      idx_r <= word_index(axi_aw_addr);
      len_r <= axi_aw_len;
      cnt_r <= 8'd0;
      err_r <= 1'b0;
    end else if (ar_hs_s) begin
      id_r      <= axi_ar_id;
      idx_r     <= word_index(axi_ar_addr);
      len_r     <= axi_ar_len;
      cnt_r     <= 8'd0;
      r_valid_r <= 1'b1;
      r_last_r  <= (axi_ar_len == 8'd0);
      r_resp_r  <= in_range(word_index(axi_ar_addr)) ? 2'b00 : 2'b10;
    end else if (w_hs_s) begin
      idx_r <= idx_inc_s;
      cnt_r <= cnt_r + 8'd1;
      if (!in_range(idx_r)) begin
        err_r <= 1'b1;
      end
    end else if (r_hs_s) begin
      if (r_last_r) begin
        r_valid_r <= 1'b0;
        r_last_r  <= 1'b0;
        r_resp_r  <= 2'b00;
      end else begin
        idx_r    <= idx_inc_s;
        cnt_r    <= cnt_r + 8'd1;
        r_last_r <= ((cnt_r + 8'd1) == len_r);
        r_resp_r <= in_range(idx_inc_s) ? 2'b00 : 2'b10;
      end
    end
  end

  // Synchronous memory read of the beat presented next; held while the master stalls.
  always_ff @(posedge clock) begin
    if (ar_hs_s || (r_hs_s && !r_last_r)) begin
      rd_word_r <= mem_r[MW'(rd_idx_s)];
    end
  end

  // Byte-enabled memory write of in-range beats; the array itself is never reset.
  always_ff @(posedge clock) begin
    if (!reset && w_hs_s && in_range(idx_r)) begin
      for (int i = 0; i < 8; i++) begin
        if (axi_w_strb[i]) begin
          mem_r[MW'(idx_r)][8*i +: 8] <= axi_w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi4_mem_responder;

  localparam int          ID_W   = 4;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              axi_aw_valid = 1'b0, axi_aw_ready;
  logic [ID_W-1:0]   axi_aw_id = '0;
  logic [ADDR_W-1:0] axi_aw_addr = '0;
  logic [7:0]        axi_aw_len = '0;
  logic              axi_w_valid = 1'b0, axi_w_ready;
  logic [63:0]       axi_w_data = '0;
  logic [7:0]        axi_w_strb = '0;
  logic              axi_w_last = 1'b0;
  logic              axi_b_valid, axi_b_ready = 1'b1;
  logic [ID_W-1:0]   axi_b_id;
  logic [1:0]        axi_b_resp;
  logic              axi_ar_valid = 1'b0, axi_ar_ready;
  logic [ID_W-1:0]   axi_ar_id = '0;
  logic [ADDR_W-1:0] axi_ar_addr = '0;
  logic [7:0]        axi_ar_len = '0;
  logic              axi_r_valid, axi_r_ready = 1'b1;
  logic [ID_W-1:0]   axi_r_id;
  logic [63:0]       axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;

  always #5 clock = ~clock;

  axi4_mem_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_id(axi_aw_id),
    .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_id(axi_b_id),
    .axi_b_resp(axi_b_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_id(axi_ar_id),
    .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_id(axi_r_id),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] wdat [4];
  logic [7:0]  wstb [4];
  logic [63:0] rdat [4];
  logic [1:0]  rrsp [4];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every B/R handshake against the scoreboard and checks R stability.
  logic        stall_q = 1'b0;
  logic [70:0] stall_snap;
  always @(negedge clock) begin
    b_exp_t be;
    r_exp_t re;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && axi_r_valid)
        check("r_stable", {axi_r_id, axi_r_data, axi_r_resp, axi_r_last}, stall_snap);
      stall_q    = axi_r_valid && !axi_r_ready;
      stall_snap = {axi_r_id, axi_r_data, axi_r_resp, axi_r_last};
      if (axi_b_valid && axi_b_ready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got id=%h resp=%b with nothing expected", axi_b_id, axi_b_resp);
        end else begin
          be = bq.pop_front();
          check("b_id", axi_b_id, be.id);
          check("b_resp", axi_b_resp, be.resp);
        end
      end
      if (axi_r_valid && axi_r_ready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got data=%h with nothing expected", axi_r_data);
        end else begin
          re = rq.pop_front();
          check("r_id", axi_r_id, re.id);
          check("r_data", axi_r_data, re.data);
          check("r_resp", axi_r_resp, re.resp);
          check("r_last", axi_r_last, re.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Wait for ready on channel ch (0=aw, 1=w, 2=ar) while valid is held; bounded.
  task automatic wait_hs(input int ch, input string name);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clock);
      case (ch)
        0:       ok = axi_aw_ready;
        1:       ok = axi_w_ready;
        default: ok = axi_ar_ready;
      endcase
      @(posedge clock); #1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no handshake after %0d cycles", name, n);
    end
  endtask

  task automatic wait_drain(input string name, output int n);
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d responses still outstanding", name, bq.size() + rq.size());
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] resp);
    b_exp_t e;
    int     n;
    e.id = id; e.resp = resp;
    bq.push_back(e);
    axi_aw_valid = 1'b1; axi_aw_id = id; axi_aw_addr = addr; axi_aw_len = 8'(len);
    wait_hs(0, "aw");
    axi_aw_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      axi_w_valid = 1'b1; axi_w_data = wdat[k]; axi_w_strb = wstb[k]; axi_w_last = (k == len);
      wait_hs(1, "w");
    end
    axi_w_valid = 1'b0; axi_w_last = 1'b0;
    wait_drain("write", n);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
    r_exp_t e;
    int     n;
    for (int k = 0; k <= len; k++) begin
      e.id = id; e.data = rdat[k]; e.resp = rrsp[k]; e.last = (k == len);
      rq.push_back(e);
    end
    axi_ar_valid = 1'b1; axi_ar_id = id; axi_ar_addr = addr; axi_ar_len = 8'(len);
    wait_hs(2, "ar");
    axi_ar_valid = 1'b0;
    wait_drain("read", n);
    // First beat is accepted one edge after AR, then one beat per edge.
    check("r_cycles", n, len + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b_exp_t be;
    r_exp_t re;
    int     beats;
    int     n;
    logic [7:0] pat;

    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_aw_ready", axi_aw_ready, 1'b1);
    check("rst_ar_ready", axi_ar_ready, 1'b1);
    check("rst_w_ready", axi_w_ready, 1'b0);
    check("rst_b_valid", axi_b_valid, 1'b0);
    check("rst_r_valid", axi_r_valid, 1'b0);
    check("rst_r_last", axi_r_last, 1'b0);
    check("rst_b_resp", axi_b_resp, 2'b00);
    check("rst_r_resp", axi_r_resp, 2'b00);
    tick();

    // Four-beat write then four-beat read at BASE.
    wdat[0] = 64'h1111_1111_1111_1111; wdat[1] = 64'h2222_2222_2222_2222;
    wdat[2] = 64'h3333_3333_3333_3333; wdat[3] = 64'h4444_4444_4444_4444;
    for (int k = 0; k < 4; k++) begin wstb[k] = 8'hFF; rdat[k] = wdat[k]; rrsp[k] = 2'b00; end
    write_burst(4'h5, BASE, 3, 2'b00);
    read_burst(4'hA, BASE, 3);

    // Partial strobe merges into existing data.
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'h0F;
    write_burst(4'h3, BASE, 0, 2'b00);
    rdat[0] = 64'h1111_1111_FFFF_FFFF; rrsp[0] = 2'b00;
    read_burst(4'h1, BASE, 0);

    // Simultaneous AW and AR: write wins, AR waits until after B handshake.
    be.id = 4'h6; be.resp = 2'b00; bq.push_back(be);
    re.id = 4'h7; re.data = 64'hDEAD_BEEF_0123_4567; re.resp = 2'b00; re.last = 1'b1;
    rq.push_back(re);
    axi_aw_valid = 1'b1; axi_aw_id = 4'h6; axi_aw_addr = BASE + 32'h8; axi_aw_len = 8'd0;
    axi_ar_valid = 1'b1; axi_ar_id = 4'h7; axi_ar_addr = BASE + 32'h8; axi_ar_len = 8'd0;
    @(negedge clock);
    check("tie_aw_ready", axi_aw_ready, 1'b1);
    check("tie_ar_ready", axi_ar_ready, 1'b0);
    tick();
    axi_aw_valid = 1'b0; axi_b_ready = 1'b0;
    axi_w_valid = 1'b1; axi_w_data = 64'hDEAD_BEEF_0123_4567; axi_w_strb = 8'hFF; axi_w_last = 1'b1;
    @(negedge clock);
    check("tie_w_ready", axi_w_ready, 1'b1);
    check("tie_wdata_ar_ready", axi_ar_ready, 1'b0);
    tick();
    axi_w_valid = 1'b0; axi_w_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("bhold_valid", axi_b_valid, 1'b1);
      check("bhold_ar_ready", axi_ar_ready, 1'b0);
      tick();
    end
    axi_b_ready = 1'b1;
    wait_hs(2, "ar_after_b");
    axi_ar_valid = 1'b0;
    wait_drain("tie", n);

    // Burst straddling the top of memory: last word written, next beat rejected.
    wdat[0] = 64'hCAFE_F00D_1234_5678; wdat[1] = 64'h5555_5555_5555_5555;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    write_burst(4'h2, 32'h8000_7FF8, 1, 2'b10);
    rdat[0] = 64'hCAFE_F00D_1234_5678; rrsp[0] = 2'b00;
    rdat[1] = 64'h0;                   rrsp[1] = 2'b10;
    read_burst(4'h4, 32'h8000_7FF8, 1);
    // Rejected beat must not alias onto word 0.
    rdat[0] = 64'h1111_1111_FFFF_FFFF; rrsp[0] = 2'b00;
    read_burst(4'h8, BASE, 0);

    // Below BASE: write rejected, read returns zero with SLVERR, top word untouched.
    wdat[0] = 64'h6666_6666_6666_6666; wstb[0] = 8'hFF;
    write_burst(4'hB, 32'h7FFF_FFF8, 0, 2'b10);
    rdat[0] = 64'h0; rrsp[0] = 2'b10;
    read_burst(4'hC, 32'h7FFF_FFF8, 0);
    rdat[0] = 64'hCAFE_F00D_1234_5678; rrsp[0] = 2'b00;
    read_burst(4'hD, 32'h8000_7FF8, 0);

    // Low address bits are ignored.
    rdat[0] = 64'h3333_3333_3333_3333; rrsp[0] = 2'b00;
    read_burst(4'hE, BASE + 32'h13, 0);

    // Stalled read interrupted by reset at beat 2.
    rdat[0] = 64'h1111_1111_FFFF_FFFF; rdat[1] = 64'hDEAD_BEEF_0123_4567;
    rdat[2] = 64'h3333_3333_3333_3333; rdat[3] = 64'h4444_4444_4444_4444;
    for (int k = 0; k < 4; k++) begin
      re.id = 4'h9; re.data = rdat[k]; re.resp = 2'b00; re.last = (k == 3);
      rq.push_back(re);
    end
    axi_r_ready = 1'b0;
    axi_ar_valid = 1'b1; axi_ar_id = 4'h9; axi_ar_addr = BASE; axi_ar_len = 8'd3;
    wait_hs(2, "ar_stall");
    axi_ar_valid = 1'b0;
    pat = 8'b1011_0100;
    beats = 0;
    for (int k = 0; k < 50 && beats < 2; k++) begin
      axi_r_ready = pat[k % 8];
      @(negedge clock);
      if (axi_r_valid && axi_r_ready) beats++;
      tick();
    end
    check("stall_beats", beats, 2);
    axi_r_ready = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("stall_beat2_valid", axi_r_valid, 1'b1);
    check("stall_beat2_data", axi_r_data, 64'h3333_3333_3333_3333);
    tick();
    reset = 1'b1;
    rq.delete();
    repeat (2) tick();
    reset = 1'b0;
    axi_r_ready = 1'b1;
    @(negedge clock);
    check("post_rst_r_valid", axi_r_valid, 1'b0);
    check("post_rst_r_last", axi_r_last, 1'b0);
    check("post_rst_r_resp", axi_r_resp, 2'b00);
    check("post_rst_aw_ready", axi_aw_ready, 1'b1);
    check("post_rst_ar_ready", axi_ar_ready, 1'b1);
    check("post_rst_w_ready", axi_w_ready, 1'b0);
    check("post_rst_b_valid", axi_b_valid, 1'b0);
    tick();
    rdat[0] = 64'h3333_3333_3333_3333; rdat[1] = 64'h4444_4444_4444_4444;
    rrsp[0] = 2'b00; rrsp[1] = 2'b00;
    read_burst(4'h2, BASE + 32'h10, 1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
